alu_op_sequencer: RTL and testbench

Command-side initiator for the combinational 16-bit ALU. It accepts operand/opcode commands through a valid/ready handshake and drives registered, stable operands into the ALU. After a fixed number of cycles it samples result/carry_out/remainder and returns them on a valid/ready response channel. It traps divide-by-zero without consuming ALU time, and sits between the datapath controller and alu_16bit.

---
 rtl/alu_op_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Command-side initiator for the combinational 16-bit ALU. Accepts
//            operand/opcode commands over valid/ready, holds registered
//            operands stable on the ALU inputs, samples the ALU outputs a
//            fixed ALU_LAT cycles later and returns them on a valid/ready
//            response channel. Divide-by-zero is trapped without waiting on
//            the ALU.
// Ports    : clk, rst               clock, async active-high reset
//            cmd_valid/ready        command handshake
//            cmd_a/cmd_b/cmd_op     command operands and opcode
//            alu_a/alu_b/alu_opcode registered operands to the ALU
//            alu_result/carry_out/remainder  ALU outputs
//            rsp_valid/ready        response handshake
//            rsp_result/carry/remainder/op/div0  captured response
//            busy                   a command is in flight
// Revision : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int         ALU_LAT    = 2,
  parameter logic [3:0] DIV_OPCODE = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [3:0]  cmd_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_result,
  input  logic        alu_carry_out,
  input  logic [15:0] alu_remainder,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic [15:0] rsp_remainder,
  output logic [3:0]  rsp_op,
  output logic        rsp_div0,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    TRAP = 2'd3
  } state_t;

  // Counter starts at ALU_LAT-1 so the sample edge lands exactly ALU_LAT
  // edges after the accept edge.
  localparam logic [3:0] C_CNT_LOAD = 4'(ALU_LAT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_accept;
  logic       w_is_trap;
  logic       w_slot_free;
  logic       w_load_rsp;
  logic       w_load_trap;

  // Ready depends on state only; forced low while reset is held.
  assign cmd_ready   = (r_state == IDLE) && !rst;
  assign busy        = (r_state != IDLE);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_is_trap   = (cmd_op == DIV_OPCODE) && (cmd_b == 16'd0);
  // The slot is free if empty or being drained on this very edge.
  assign w_slot_free = !rsp_valid || rsp_ready;

  // --------------------------------------------------------------------------
  // Next-state / control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_rsp  = 1'b0;
    w_load_trap = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_trap) begin
            w_state_nxt = TRAP;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = EXEC;
            w_cnt_nxt   = C_CNT_LOAD;
          end
        end
      end
      EXEC: begin
        if (r_cnt == 4'd0) begin
          if (w_slot_free) begin
            w_load_rsp  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      WAIT: begin
        // Operands are still held, so the ALU outputs remain valid here.
        if (w_slot_free) begin
          w_load_rsp  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      TRAP: begin
        if (w_slot_free) begin
          w_load_rsp  = 1'b1;
          w_load_trap = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Operand registers: loaded only on accept, held for the whole command
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= 16'd0;
      alu_b      <= 16'd0;
      alu_opcode <= 4'd0;
    end else if (w_accept) begin
      alu_a      <= cmd_a;
      alu_b      <= cmd_b;
      alu_opcode <= cmd_op;
    end
  end

  // --------------------------------------------------------------------------
  // Response slot: a load on the draining edge wins and keeps valid high
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid     <= 1'b0;
      rsp_result    <= 32'd0;
      rsp_carry     <= 1'b0;
      rsp_remainder <= 16'd0;
      rsp_op        <= 4'd0;
      rsp_div0      <= 1'b0;
    end else if (w_load_rsp) begin
      rsp_valid <= 1'b1;
      rsp_op    <= alu_opcode;
      if (w_load_trap) begin
        // Dividend is returned as the remainder of a divide-by-zero.
        rsp_result    <= 32'd0;
        rsp_carry     <= 1'b0;
        rsp_remainder <= alu_a;
        rsp_div0      <= 1'b1;
      end else begin
        rsp_result    <= alu_result;
        rsp_carry     <= alu_carry_out;
        rsp_remainder <= alu_remainder;
        rsp_div0      <= 1'b0;
      end
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Self-checking bench for alu_op_sequencer. Three instances
//            (ALU_LAT = 2, 3, 1) share clock and reset; each has a small
//            behavioural ALU on its operand outputs. Expected responses are
//            queued on every command handshake and compared on every
//            response handshake; directed checks cover timing corners.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

  localparam int         N      = 3;
  localparam logic [3:0] DIV_OP = 4'b0011;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] res;
    logic        carry;
    logic [15:0] rem;
    logic [3:0]  op;
    logic        div0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid     [N];
  logic        cmd_ready     [N];
  logic [15:0] cmd_a         [N];
  logic [15:0] cmd_b         [N];
  logic [3:0]  cmd_op        [N];
  logic [15:0] alu_a         [N];
  logic [15:0] alu_b         [N];
  logic [3:0]  alu_opcode    [N];
  logic [31:0] alu_result    [N];
  logic        alu_carry_out [N];
  logic [15:0] alu_remainder [N];
  logic        rsp_valid     [N];
  logic        rsp_ready     [N];
  logic [31:0] rsp_result    [N];
  logic        rsp_carry     [N];
  logic [15:0] rsp_remainder [N];
  logic [3:0]  rsp_op        [N];
  logic        rsp_div0      [N];
  logic        busy          [N];

  exp_t sb[$];
  int   rsp_cnt [N];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [48:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] op);
    logic [16:0] s;
    logic [31:0] r;
    logic        c;
    logic [15:0] m;
    r = 32'd0;
    c = 1'b0;
    m = 16'd0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = {16'd0, s[15:0]}; c = s[16]; end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; r = {16'd0, s[15:0]}; c = s[16]; end
      4'd2: r = 32'(a) * 32'(b);
      4'd3: if (b != 16'd0) begin r = {16'd0, a / b}; m = a % b; end
      default: r = {16'd0, a ^ b};
    endcase
    return {c, r, m};
  endfunction

  function automatic exp_t exp_of(input int i, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] op);
    exp_t        e;
    logic [48:0] r;
    e.idx = 2'(i);
    e.op  = op;
    if (op == DIV_OP && b == 16'd0) begin
      e.res = 32'd0; e.carry = 1'b0; e.rem = a; e.div0 = 1'b1;
    end else begin
      r = alu_fn(a, b, op);
      e.carry = r[48]; e.res = r[47:16]; e.rem = r[15:0]; e.div0 = 1'b0;
    end
    return e;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_alu
    assign {alu_carry_out[g], alu_result[g], alu_remainder[g]} =
      alu_fn(alu_a[g], alu_b[g], alu_opcode[g]);
  end

  alu_op_sequencer #(.ALU_LAT(2), .DIV_OPCODE(DIV_OP)) u_dut_l2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_opcode(alu_opcode[0]),
    .alu_result(alu_result[0]), .alu_carry_out(alu_carry_out[0]),
    .alu_remainder(alu_remainder[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_result(rsp_result[0]), .rsp_carry(rsp_carry[0]),
    .rsp_remainder(rsp_remainder[0]), .rsp_op(rsp_op[0]),
    .rsp_div0(rsp_div0[0]), .busy(busy[0])
  );

  alu_op_sequencer #(.ALU_LAT(3), .DIV_OPCODE(DIV_OP)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_opcode(alu_opcode[1]),
    .alu_result(alu_result[1]), .alu_carry_out(alu_carry_out[1]),
    .alu_remainder(alu_remainder[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_result(rsp_result[1]), .rsp_carry(rsp_carry[1]),
    .rsp_remainder(rsp_remainder[1]), .rsp_op(rsp_op[1]),
    .rsp_div0(rsp_div0[1]), .busy(busy[1])
  );

  alu_op_sequencer #(.ALU_LAT(1), .DIV_OPCODE(DIV_OP)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_a(cmd_a[2]), .cmd_b(cmd_b[2]), .cmd_op(cmd_op[2]),
    .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_opcode(alu_opcode[2]),
    .alu_result(alu_result[2]), .alu_carry_out(alu_carry_out[2]),
    .alu_remainder(alu_remainder[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_result(rsp_result[2]), .rsp_carry(rsp_carry[2]),
    .rsp_remainder(rsp_remainder[2]), .rsp_op(rsp_op[2]),
    .rsp_div0(rsp_div0[2]), .busy(busy[2])
  );

  task automatic chk(input string tag, input bit ok);
    total++;
    if (ok) passed++;
    else $error("FAIL %s", tag);
  endtask

  task automatic drive(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op);
    cmd_valid[i] = 1'b1;
    cmd_a[i]     = a;
    cmd_b[i]     = b;
    cmd_op[i]    = op;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (cmd_valid[i] && cmd_ready[i])
          sb.push_back(exp_of(i, cmd_a[i], cmd_b[i], cmd_op[i]));
        if (rsp_valid[i] && rsp_ready[i]) begin
          int f;
          f = -1;
          foreach (sb[j]) if (f < 0 && int'(sb[j].idx) == i) f = j;
          rsp_cnt[i]++;
          if (f < 0) begin
            chk("sb_unexpected_rsp", 1'b0);
          end else begin
            chk("sb_result", rsp_result[i] === sb[f].res);
            chk("sb_carry", rsp_carry[i] === sb[f].carry);
            chk("sb_remainder", rsp_remainder[i] === sb[f].rem);
            chk("sb_op", rsp_op[i] === sb[f].op);
            chk("sb_div0", rsp_div0[i] === sb[f].div0);
            sb.delete(f);
          end
        end
      end
    end
  end

  initial begin
    longint prev_t;
    longint acc_t;
    bit     got;
    int     sb1;
    for (int i = 0; i < N; i++) begin
      cmd_valid[i] = 1'b0; cmd_a[i] = 16'd0; cmd_b[i] = 16'd0; cmd_op[i] = 4'd0;
      rsp_ready[i] = 1'b0; rsp_cnt[i] = 0;
    end

    #2;
    chk("rst_cmd_ready", cmd_ready[0] === 1'b0);
    chk("rst_busy", busy[0] === 1'b0);
    chk("rst_rsp_valid", rsp_valid[0] === 1'b0);
    chk("rst_alu_a", alu_a[0] === 16'd0);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("rel_cmd_ready", cmd_ready[0] === 1'b1);
    step();

    drive(0, 16'hFFFF, 16'h0001, 4'd0);
    step(); cmd_valid[0] = 1'b0;
    chk("add_alu_a", alu_a[0] === 16'hFFFF);
    chk("add_alu_b", alu_b[0] === 16'h0001);
    chk("add_busy", busy[0] === 1'b1);
    chk("add_cmd_ready_low", cmd_ready[0] === 1'b0);
    step();
    chk("add_no_rsp_k1", rsp_valid[0] === 1'b0);
    chk("add_alu_a_held", alu_a[0] === 16'hFFFF);
    step();
    chk("add_rsp_valid", rsp_valid[0] === 1'b1);
    chk("add_rsp_result", rsp_result[0] === 32'h0);
    chk("add_rsp_carry", rsp_carry[0] === 1'b1);
    chk("add_rsp_div0", rsp_div0[0] === 1'b0);
    chk("add_idle_ready", cmd_ready[0] === 1'b1);
    rsp_ready[0] = 1'b1;
    step();
    chk("add_drained", rsp_valid[0] === 1'b0);

    drive(0, 16'h1234, 16'h0000, DIV_OP);
    step(); cmd_valid[0] = 1'b0;
    chk("div0_busy", busy[0] === 1'b1);
    chk("div0_no_rsp_yet", rsp_valid[0] === 1'b0);
    step();
    chk("div0_rsp_valid", rsp_valid[0] === 1'b1);
    chk("div0_flag", rsp_div0[0] === 1'b1);
    chk("div0_result", rsp_result[0] === 32'h0);
    chk("div0_remainder", rsp_remainder[0] === 16'h1234);
    chk("div0_ready_again", cmd_ready[0] === 1'b1);
    step();
    chk("div0_drained", rsp_valid[0] === 1'b0);

    rsp_ready[0] = 1'b0;
    drive(0, 16'd3, 16'd4, 4'd0);
    step(); cmd_valid[0] = 1'b0;
    step(); step();
    chk("bp_first_valid", rsp_valid[0] === 1'b1);
    chk("bp_first_result", rsp_result[0] === 32'd7);
    drive(0, 16'd7, 16'd5, 4'd1);
    step(); cmd_valid[0] = 1'b0;
    step(); step();
    chk("bp_wait_busy", busy[0] === 1'b1);
    chk("bp_wait_cmd_ready", cmd_ready[0] === 1'b0);
    chk("bp_alu_a_held", alu_a[0] === 16'd7);
    chk("bp_alu_b_held", alu_b[0] === 16'd5);
    chk("bp_first_stable", rsp_result[0] === 32'd7);
    step();
    chk("bp_still_wait", busy[0] === 1'b1);
    chk("bp_op_stable", rsp_op[0] === 4'd0);
    rsp_ready[0] = 1'b1;
    step();
    chk("bp_reload_valid", rsp_valid[0] === 1'b1);
    chk("bp_reload_result", rsp_result[0] === 32'h2);
    chk("bp_reload_op", rsp_op[0] === 4'd1);
    chk("bp_idle", busy[0] === 1'b0);
    step();
    chk("bp_drained", rsp_valid[0] === 1'b0);

    rsp_ready[1] = 1'b1;
    prev_t = 0;
    for (int n = 0; n < 8; n++) begin
      drive(1, 16'(n * 1000 + 17), 16'(n + 3), 4'(n % 5));
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (cmd_ready[1]) got = 1'b1;
      end
      if (!got) chk("stream_accept_timeout", 1'b0);
      @(posedge clk);
      acc_t = longint'($time);
      #1;
      if (n > 0) chk("stream_interval", (acc_t - prev_t) == 40);
      prev_t = acc_t;
    end
    cmd_valid[1] = 1'b0;
    for (int t = 0; t < 50 && rsp_cnt[1] < 8; t++) @(posedge clk);
    step(); step(); step();
    chk("stream_rsp_count", rsp_cnt[1] == 8);
    sb1 = 0;
    foreach (sb[j]) if (sb[j].idx == 2'd1) sb1++;
    chk("stream_sb_empty", sb1 == 0);

    rsp_ready[2] = 1'b1;
    drive(2, 16'h0100, 16'h0100, 4'd2);
    step(); cmd_valid[2] = 1'b0;
    chk("l1_busy", busy[2] === 1'b1);
    chk("l1_no_rsp", rsp_valid[2] === 1'b0);
    step();
    chk("l1_rsp_valid", rsp_valid[2] === 1'b1);
    chk("l1_rsp_result", rsp_result[2] === 32'h0001_0000);
    chk("l1_ready_again", cmd_ready[2] === 1'b1);
    chk("l1_busy_clear", busy[2] === 1'b0);
    step();
    chk("l1_drained", rsp_valid[2] === 1'b0);

    rsp_ready[0] = 1'b0;
    drive(0, 16'd9, 16'd9, 4'd0);
    step(); cmd_valid[0] = 1'b0;
    step(); step();
    drive(0, 16'd5, 16'd5, 4'd0);
    step(); cmd_valid[0] = 1'b0;
    chk("mid_busy", busy[0] === 1'b1);
    chk("mid_pending", rsp_valid[0] === 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", busy[0] === 1'b0);
    chk("async_cmd_ready", cmd_ready[0] === 1'b0);
    chk("async_rsp_valid", rsp_valid[0] === 1'b0);
    chk("async_alu_a", alu_a[0] === 16'd0);
    chk("async_alu_opcode", alu_opcode[0] === 4'd0);
    chk("async_rsp_result", rsp_result[0] === 32'd0);
    sb.delete();
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready[0] === 1'b1);
    chk("post_rst_busy", busy[0] === 1'b0);
    step();

    rsp_ready[0] = 1'b1;
    drive(0, 16'h00F0, 16'h000F, 4'd5);
    step(); cmd_valid[0] = 1'b0;
    step();
    step();
    chk("post_xor_result", rsp_result[0] === 32'h0000_00FF);
    step(); step();
    chk("final_sb_empty", sb.size() == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
